// File: rtl/final_bits_sequencer.sv
// End-of-frame flush controller: feeds cnt/low to the final-bits generator for one
// evaluation cycle, then streams its 0/1/2 words out over valid/ready.
// Optional: define FINAL_SEQ_STALL_CNT_EN to add the out_stall_cnt backpressure counter.
module final_bits_sequencer #(
    parameter int OUTPUT_BITSTREAM_WIDTH = 16,
    parameter int D_SIZE                 = 5,
    parameter int LOW_WIDTH              = 24
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_flag_final,
    input  logic [D_SIZE-1:0]                 in_cnt,
    input  logic [LOW_WIDTH-1:0]              in_low,
    output logic                              gen_flag_final,
    output logic [D_SIZE-1:0]                 gen_cnt,
    output logic [LOW_WIDTH-1:0]              gen_low,
    input  logic [1:0]                        gen_flag,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_1,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] gen_bit_2,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_bitstream,
    output logic                              out_last,
    output logic                              out_busy,
    output logic                              out_done
`ifdef FINAL_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                       out_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_EMIT1,
        S_EMIT2,
        S_DONE
    } state_t;

    state_t                              state, state_nxt;
    logic [D_SIZE-1:0]                   cnt_q;
    logic [LOW_WIDTH-1:0]                low_q;
    logic [1:0]                          flag_q;
    logic [OUTPUT_BITSTREAM_WIDTH-1:0]   bit1_q, bit2_q;
    logic                                one_word;
    logic                                req_accept;

    assign one_word   = (flag_q == 2'b01);
    assign req_accept = (state == S_IDLE) && in_flag_final;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            low_q  <= '0;
            flag_q <= '0;
            bit1_q <= '0;
            bit2_q <= '0;
        end else begin
            state <= state_nxt;
            if (req_accept) begin
                cnt_q <= in_cnt;
                low_q <= in_low;
            end
            if (state == S_EVAL) begin
                flag_q <= gen_flag;
                bit1_q <= gen_bit_1;
                bit2_q <= gen_bit_2;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        gen_flag_final = 1'b0;
        out_valid      = 1'b0;
        out_bitstream  = '0;
        out_last       = 1'b0;
        out_done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_flag_final) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                gen_flag_final = 1'b1;
                // 11 is treated as a two-word result
                state_nxt = (gen_flag == 2'b00) ? S_DONE : S_EMIT1;
            end
            S_EMIT1: begin
                out_valid     = 1'b1;
                out_bitstream = bit1_q;
                out_last      = one_word;
                if (out_ready) state_nxt = one_word ? S_DONE : S_EMIT2;
            end
            S_EMIT2: begin
                out_valid     = 1'b1;
                out_bitstream = bit2_q;
                out_last      = 1'b1;
                if (out_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_busy = (state != S_IDLE);

    // Operand isolation: the generator only sees live operands during EVAL.
    assign gen_cnt = gen_flag_final ? cnt_q : '0;
    assign gen_low = gen_flag_final ? low_q : '0;

`ifdef FINAL_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || req_accept) begin
            out_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (out_stall_cnt != 16'hFFFF)) begin
            out_stall_cnt <= out_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/final_bits_sequencer.md
Name: final_bits_sequencer

Overview:
Controller that runs the end-of-frame flush (OD_EC_ENC_DONE) through the final-bits generator datapath.
- On a flush request it registers cnt/low and drives them into the generator with the final flag asserted for exactly one evaluation cycle.
- It captures the word-count flag and both candidate words, then streams 0, 1 or 2 bitstream words to the output packer over a valid/ready handshake.
- It signals completion with a one-cycle done pulse.
- It sits between the encoder's range/low state registers and the output bitstream buffer.

Parameters:
OUTPUT_BITSTREAM_WIDTH, 16, width of each emitted bitstream word
D_SIZE, 5, width of cnt
LOW_WIDTH, 24, width of low

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_flag_final  in  1  flush request; sampled only in IDLE
in_cnt  in  D_SIZE  cnt value, sampled with the request
in_low  in  LOW_WIDTH  low value, sampled with the request
gen_flag_final  out  1  final flag to generator; high only in EVAL
gen_cnt  out  D_SIZE  registered cnt to generator
gen_low  out  LOW_WIDTH  registered low to generator
gen_flag  in  2  generator word count: 00=0 words, 01=1 word, 10=2 words
gen_bit_1  in  OUTPUT_BITSTREAM_WIDTH  generator first word
gen_bit_2  in  OUTPUT_BITSTREAM_WIDTH  generator second word
out_valid  out  1  out_bitstream holds a valid word
out_ready  in  1  downstream accepts the word when out_valid&&out_ready
out_bitstream  out  OUTPUT_BITSTREAM_WIDTH  emitted word
out_last  out  1  marks the final word of the flush
out_busy  out  1  high in every state except IDLE
out_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset values: all outputs 0; internal cnt/low/flag/word registers 0; state IDLE.
- States: IDLE, EVAL, EMIT1, EMIT2, DONE.
- IDLE:
  - If in_flag_final=1: register in_cnt/in_low into gen_cnt/gen_low and go to EVAL.
  - Otherwise stay in IDLE.
- EVAL (exactly 1 cycle):
  - gen_flag_final=1.
  - At the clock edge, capture gen_flag, gen_bit_1, gen_bit_2.
  - Next state: 00 -> DONE; 01 -> EMIT1 with last flag set; 10 or 11 -> EMIT1 (11 treated as 10).
- gen_cnt/gen_low are forced to 0 whenever gen_flag_final=0 (operand isolation: the generator sees zeros outside EVAL).
- EMIT1:
  - out_valid=1, out_bitstream=captured bit_1, out_last=1 iff count was 1.
  - On handshake: go to EMIT2 if count is 2, else DONE.
- EMIT2:
  - out_valid=1, out_bitstream=captured bit_2, out_last=1.
  - On handshake: go to DONE.
- DONE: out_done=1 for one cycle, then IDLE.
- Word order is always bit_1 then bit_2.
- Handshake rules:
  - out_valid never drops, and out_bitstream/out_last never change, while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- Latency with out_ready held at 1:
  - Request in cycle 0; EVAL in cycle 1.
  - First word valid in cycle 2.
  - out_done in cycle 2 (0 words), cycle 3 (1 word) or cycle 4 (2 words).
- in_flag_final while out_busy=1 is ignored and not queued. A request in the same cycle as DONE is ignored; a request in the cycle after DONE is accepted.
- Reset asserted mid-flush: next cycle is IDLE with all outputs 0. No out_done, no partial word.

Optional Feature:
Macro FINAL_SEQ_STALL_CNT_EN.
- Defined: adds output port out_stall_cnt, 16 bits.
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 0xFFFF.
  - Cleared on reset and on every accepted request.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
Bench instantiates the real final-bits generator wired to the gen_* ports.
1. Zero words: reset, then request cnt=5'b10111 (-9), low=0x000000 -> gen_flag=00; no out_valid ever; out_done in cycle 2; out_busy high in cycles 1-2.
2. One word: request cnt=0, low=0x000000, out_ready=1 -> one word 0x0080 with out_last=1 in cycle 2; out_done in cycle 3.
3. Two words: request cnt=8, low=0x000000, out_ready=1 -> 0x0000 (out_last=0) in cycle 2, then 0x0080 (out_last=1) in cycle 3; out_done in cycle 4.
4. Backpressure: repeat case 3 with out_ready=0 for cycles 2-6 -> word 0x0000 stable for 5 cycles, then both words accepted in order. With FINAL_SEQ_STALL_CNT_EN defined, out_stall_cnt=5.
5. Ignored request and reset: in_flag_final pulses during EMIT1 -> ignored, exactly one flush completes. Separately, reset asserted in EMIT2 -> IDLE next cycle, out_valid=0, no out_done; a new request then completes normally.
